// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_pkg;

    // Pattern modes as encoded on the command interface.
    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_WALK   = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_PAUSE  = 2'b11
    } mode_e;

    // Travel direction of the lit LED in BOUNCE mode.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Per-bit LED levels; the bank is active-low.
    localparam logic LED_ALL_OFF = 1'b1;
    localparam logic LED_ALL_ON  = 1'b0;

endpackage : led_pkg

// File: rtl/tick_prescaler.sv
// Divides the incoming tick strobe by (rate+1) and emits an advance strobe.
module tick_prescaler #(
    parameter int RATE_W = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              tick_i,
    input  logic [RATE_W-1:0] rate_i,
    input  logic              clear_i,
    input  logic              freeze_i,
    output logic              advance_o
);

    logic [RATE_W-1:0] tick_cnt_q;
    logic [RATE_W-1:0] tick_cnt_d;

    // Advance fires on the tick that completes a full count.
    assign advance_o = tick_i & ~freeze_i & (tick_cnt_q == rate_i);

    // Next count: clear wins, freeze holds, a tick counts or wraps.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clear_i) begin
            tick_cnt_d = {RATE_W{1'b0}};
        end else if (freeze_i || !tick_i) begin
            tick_cnt_d = tick_cnt_q;
        end else if (tick_cnt_q == rate_i) begin
            tick_cnt_d = {RATE_W{1'b0}};
        end else begin
            tick_cnt_d = tick_cnt_q + {{(RATE_W-1){1'b0}}, 1'b1};
        end
    end

    // Tick counter register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            tick_cnt_q <= {RATE_W{1'b0}};
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/led_sequencer.sv
// LED pattern sequencer: command handshake, mode FSM and active-low LED datapath.
module led_sequencer
    import led_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RATE_W    = 4,
    parameter int INIT_RATE = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [RATE_W-1:0] cmd_rate,
    output logic [WIDTH-1:0]  LED,
    output logic              step
);

    localparam int POS_W = $clog2(WIDTH);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [WIDTH-1:0] LED_OFF  = {WIDTH{LED_ALL_OFF}};
    localparam logic [WIDTH-1:0] LED_ON   = {WIDTH{LED_ALL_ON}};

    // Active-low one-hot pattern lighting only LED p.
    function automatic logic [WIDTH-1:0] led_for_pos(input logic [POS_W-1:0] p);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        return ~(one << p);
    endfunction

    mode_e             mode_q,      mode_d;
    dir_e              dir_q,       dir_d;
    logic [POS_W-1:0]  pos_q,       pos_d;
    logic [RATE_W-1:0] rate_q,      rate_d;
    logic              phase_q,     phase_d;
    logic              pending_q,   pending_d;
    mode_e             pend_mode_q, pend_mode_d;
    logic [RATE_W-1:0] pend_rate_q, pend_rate_d;
    logic [WIDTH-1:0]  led_q,       led_d;
    logic              step_q,      step_d;

    logic advance_s;
    logic accept_s;
    logic apply_s;

    assign cmd_ready = ~pending_q;
    assign LED       = led_q;
    assign step      = step_q;

    assign accept_s = cmd_valid & ~pending_q;
    assign apply_s  = pending_q & (advance_s | ((mode_q == MODE_PAUSE) & tick));

    tick_prescaler #(
        .RATE_W (RATE_W)
    ) u_prescaler (
        .clock_i   (clock),
        .reset_i   (reset),
        .tick_i    (tick),
        .rate_i    (rate_q),
        .clear_i   (apply_s),
        .freeze_i  (mode_q == MODE_PAUSE),
        .advance_o (advance_s)
    );

    // Next-state logic: apply a pending command, or step the current pattern.
    always_comb begin
        mode_d      = mode_q;
        dir_d       = dir_q;
        pos_d       = pos_q;
        rate_d      = rate_q;
        phase_d     = phase_q;
        pending_d   = pending_q;
        pend_mode_d = pend_mode_q;
        pend_rate_d = pend_rate_q;
        led_d       = led_q;
        step_d      = 1'b0;

        if (apply_s) begin
            // The advance that applies a command does not also step the pattern.
            mode_d    = pend_mode_q;
            rate_d    = pend_rate_q;
            pending_d = 1'b0;
            case (pend_mode_q)
                MODE_BLINK: begin
                    phase_d = 1'b1;
                    led_d   = LED_ON;
                    step_d  = 1'b1;
                end
                MODE_BOUNCE: begin
                    dir_d = (pos_q == POS_MAX) ? DIR_DOWN : DIR_UP;
                end
                default: begin
                end
            endcase
        end else if (advance_s) begin
            case (mode_q)
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (pos_q == POS_MAX) begin
                            pos_d = POS_MAX - POS_ONE;
                            dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end else begin
                        if (pos_q == POS_ZERO) begin
                            pos_d = POS_ONE;
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                        end
                    end
                    led_d  = led_for_pos(pos_d);
                    step_d = 1'b1;
                end
                MODE_WALK: begin
                    pos_d  = (pos_q == POS_MAX) ? POS_ZERO : pos_q + POS_ONE;
                    led_d  = led_for_pos(pos_d);
                    step_d = 1'b1;
                end
                MODE_BLINK: begin
                    phase_d = ~phase_q;
                    led_d   = phase_d ? LED_ON : LED_OFF;
                    step_d  = 1'b1;
                end
                default: begin
                end
            endcase
        end else begin
            step_d = 1'b0;
        end

        // Apply and accept cannot coincide: accept needs pending clear, apply needs it set.
        if (accept_s) begin
            pending_d   = 1'b1;
            pend_mode_d = mode_e'(cmd_mode);
            pend_rate_d = cmd_rate;
        end else begin
            pending_d = pending_d;
        end
    end

    // Sequencer state and registered outputs; reset drops any pending command.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q      <= MODE_BOUNCE;
            dir_q       <= DIR_UP;
            pos_q       <= POS_ZERO;
            rate_q      <= RATE_W'(INIT_RATE);
            phase_q     <= 1'b0;
            pending_q   <= 1'b0;
            pend_mode_q <= MODE_BOUNCE;
            pend_rate_q <= {RATE_W{1'b0}};
            led_q       <= led_for_pos(POS_ZERO);
            step_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            pos_q       <= pos_d;
            rate_q      <= rate_d;
            phase_q     <= phase_d;
            pending_q   <= pending_d;
            pend_mode_q <= pend_mode_d;
            pend_rate_q <= pend_rate_d;
            led_q       <= led_d;
            step_q      <= step_d;
        end
    end

endmodule : led_sequencer

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: a reference model predicts LED/step/ready per cycle.
module tb_led_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_rate;
    logic [7:0] LED;
    logic       step;

    int n_checks = 0;
    int n_pass   = 0;
    int step_count = 0;
    logic [9:0] exp_q[$];

    // Reference model state
    int m_mode, m_pos, m_dir, m_rate, m_cnt, m_pend, m_pmode, m_prate, m_phase;
    logic [7:0] m_led;
    logic       m_step;

    led_sequencer #(.WIDTH(8), .RATE_W(4), .INIT_RATE(0)) dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_rate  (cmd_rate),
        .LED       (LED),
        .step      (step)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] onecold(input int p);
        logic [7:0] b;
        b = 8'h01;
        return ~(b << p);
    endfunction

    task automatic model_step(input logic r, input logic t, input logic v,
                              input logic [1:0] md, input logic [3:0] rt);
        int adv, app, acc;
        if (r) begin
            m_mode = 0; m_pos = 0; m_dir = 0; m_rate = 0; m_cnt = 0;
            m_pend = 0; m_phase = 0; m_led = 8'hFE; m_step = 1'b0;
        end else begin
            acc = (v && m_pend == 0) ? 1 : 0;
            adv = 0;
            if (m_mode != 3 && t) begin
                if (m_cnt == m_rate) begin adv = 1; m_cnt = 0; end
                else m_cnt++;
            end
            app = (m_pend != 0 && (adv != 0 || (m_mode == 3 && t))) ? 1 : 0;
            m_step = 1'b0;
            if (app != 0) begin
                m_mode = m_pmode; m_rate = m_prate; m_pend = 0; m_cnt = 0;
                if (m_mode == 2) begin m_phase = 1; m_led = 8'h00; m_step = 1'b1; end
                else if (m_mode == 0) m_dir = (m_pos == 7) ? 1 : 0;
            end else if (adv != 0) begin
                case (m_mode)
                    0: begin
                        if (m_dir == 0) begin
                            if (m_pos == 7) begin m_pos = 6; m_dir = 1; end else m_pos++;
                        end else begin
                            if (m_pos == 0) begin m_pos = 1; m_dir = 0; end else m_pos--;
                        end
                    end
                    1: m_pos = (m_pos + 1) % 8;
                    2: begin
                        m_phase = (m_phase == 0) ? 1 : 0;
                        m_led = (m_phase != 0) ? 8'h00 : 8'hFF;
                    end
                    default: ;
                endcase
                if (m_mode != 2) m_led = onecold(m_pos);
                m_step = 1'b1;
            end
            if (acc != 0) begin m_pend = 1; m_pmode = int'(md); m_prate = int'(rt); end
        end
    endtask

    // Drive one cycle, predict its outcome, then compare after the edge.
    task automatic cyc(input string tag, input logic r, input logic t, input logic v,
                       input logic [1:0] md, input logic [3:0] rt);
        logic [9:0] want;
        reset = r; tick = t; cmd_valid = v; cmd_mode = md; cmd_rate = rt;
        model_step(r, t, v, md, rt);
        exp_q.push_back({m_led, m_step, (m_pend == 0)});
        @(posedge clock);
        #1;
        if (step) step_count++;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            want = exp_q.pop_front();
            check_eq(tag, {22'd0, LED, step, cmd_ready}, {22'd0, want});
        end
    endtask

    logic [7:0] prev_led;
    logic       seen_wrap;

    initial begin
        reset = 1'b1; tick = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'b00; cmd_rate = 4'd0;
        m_pmode = 0; m_prate = 0;

        // Reset, with a handshake offered during reset that must be discarded
        cyc("rst", 1'b1, 1'b0, 1'b1, 2'b01, 4'd5);
        cyc("rst", 1'b1, 1'b1, 1'b1, 2'b01, 4'd5);
        check_eq("rst_led", {24'd0, LED}, 32'h0000_00FE);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);

        // 1: BOUNCE at rate 0 for 16 ticks
        step_count = 0;
        for (int i = 0; i < 16; i++) cyc("bounce", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("bounce_steps", 32'(step_count), 32'd16);
        check_eq("bounce_end", {24'd0, LED}, 32'h0000_00FB);

        // 2: WALK at rate 2; pending until next advance, then wrap 7F -> FE
        cyc("walk_cmd", 1'b0, 1'b0, 1'b1, 2'b01, 4'd2);
        check_eq("walk_ready_low", {31'd0, cmd_ready}, 32'd0);
        cyc("walk_apply", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("walk_apply_led", {23'd0, LED, step}, {23'd0, 8'hFB, 1'b0});
        seen_wrap = 1'b0;
        for (int i = 0; i < 18; i++) begin
            prev_led = LED;
            cyc("walk", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
            if (prev_led == 8'h7F && LED == 8'hFE) seen_wrap = 1'b1;
        end
        check_eq("walk_wrap", {31'd0, seen_wrap}, 32'd1);
        for (int i = 0; i < 21; i++) cyc("walk", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("walk_pos7", {24'd0, LED}, 32'h0000_007F);

        // 3: BLINK; apply lights all, then FF,00,FF
        cyc("blink_cmd", 1'b0, 1'b0, 1'b1, 2'b10, 4'd0);
        for (int i = 0; i < 3; i++) cyc("blink_wait", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("blink_apply", {23'd0, LED, step}, {23'd0, 8'h00, 1'b1});
        for (int i = 0; i < 3; i++) cyc("blink", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("blink_end", {24'd0, LED}, 32'h0000_00FF);

        // 4: PAUSE freezes; BOUNCE at pos 7 applies on a raw tick and heads down
        cyc("pause_cmd", 1'b0, 1'b0, 1'b1, 2'b11, 4'd0);
        cyc("pause_apply", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        step_count = 0;
        for (int i = 0; i < 10; i++) cyc("pause", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("pause_steps", 32'(step_count), 32'd0);
        check_eq("pause_led", {24'd0, LED}, 32'h0000_00FF);
        cyc("bounce_cmd", 1'b0, 1'b0, 1'b1, 2'b00, 4'd0);
        cyc("bounce_apply", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("bounce_apply_ready", {31'd0, cmd_ready}, 32'd1);
        cyc("bounce_down", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("bounce_down_led", {24'd0, LED}, 32'h0000_00BF);

        // 5: cmd_valid held through pending; second command taken after apply
        cyc("hold_a", 1'b0, 1'b0, 1'b1, 2'b01, 4'd1);
        cyc("hold_b0", 1'b0, 1'b0, 1'b1, 2'b10, 4'd0);
        check_eq("hold_no_accept", {31'd0, cmd_ready}, 32'd0);
        cyc("hold_apply", 1'b0, 1'b1, 1'b1, 2'b10, 4'd0);
        check_eq("hold_apply_ready", {31'd0, cmd_ready}, 32'd1);
        cyc("hold_b1", 1'b0, 1'b0, 1'b1, 2'b10, 4'd0);
        check_eq("hold_second_accept", {31'd0, cmd_ready}, 32'd0);
        for (int i = 0; i < 2; i++) cyc("hold_run", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("hold_blink", {24'd0, LED}, 32'h0000_0000);

        // 6: reset mid-BLINK with a pending command
        cyc("rst6_cmd", 1'b0, 1'b0, 1'b1, 2'b01, 4'd3);
        check_eq("rst6_pending", {31'd0, cmd_ready}, 32'd0);
        cyc("rst6_reset", 1'b1, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("rst6_led", {23'd0, LED, cmd_ready}, {23'd0, 8'hFE, 1'b1});
        cyc("rst6_after", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        check_eq("rst6_dropped", {23'd0, LED, step}, {23'd0, 8'hFD, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_led_sequencer
